matvec_mac_engine: RTL

MATVEC_MAC_ENGINE -- requirements
Module: matvec_mac_engine

---
 rtl/matvec_mac_engine.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/matvec_mac_engine.sv
// Matrix-vector multiply engine: computes y = A*x one row at a time.
// x is streamed in first and buffered. A is then streamed row-major and
// each row is reduced by a single multiply-accumulate. Each finished row
// is scaled, saturated and offered on the y stream before the next row starts.
module matvec_mac_engine #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 48,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int FRAC_BITS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic              x_valid,
    input  logic [DATA_W-1:0] x_data,
    output logic              x_ready,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    input  logic              y_ready,
    output logic              busy,
    output logic              done,
    output logic              sat
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    // Saturation bounds of a DATA_W signed word, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_X = 2'd1,
        MAC    = 2'd2,
        EMIT   = 2'd3
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic [COL_W-1:0]          col_reg;
    logic [ROW_W-1:0]          row_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic signed [DATA_W-1:0]  x_buf [COLS];
    logic [DATA_W-1:0]         y_data_reg;
    logic                      sat_reg;
    logic                      done_reg;

    logic                      x_fire;
    logic                      a_fire;
    logic                      y_fire;
    logic                      col_last;
    logic                      row_last;
    logic [COLS-1:0]           x_wr;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [ACC_W-1:0]    acc_shift;
    logic                       clamp_hi;
    logic                       clamp_lo;
    logic [DATA_W-1:0]          y_sat;

    assign x_fire   = x_valid & x_ready;
    assign a_fire   = a_valid & a_ready;
    assign y_fire   = y_valid & y_ready;
    assign col_last = (col_reg == COL_LAST);
    assign row_last = (row_reg == ROW_LAST);

    // One write strobe per x buffer slot, selected by the column counter.
    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_x_wr
            assign x_wr[gi] = x_fire && !clear && (col_reg == COL_W'(gi));
        end
    endgenerate

    // Full-precision product, sign-extended and accumulated, then scaled and clamped.
    assign prod      = $signed(a_data) * x_buf[col_reg];
    assign prod_ext  = ACC_W'(prod);
    assign acc_sum   = acc_reg + prod_ext;
    assign acc_shift = acc_sum >>> FRAC_BITS;
    assign clamp_hi  = (acc_shift > Y_MAX);
    assign clamp_lo  = (acc_shift < Y_MIN);
    assign y_sat     = clamp_hi ? Y_MAX[DATA_W-1:0] :
                       clamp_lo ? Y_MIN[DATA_W-1:0] :
                                  acc_shift[DATA_W-1:0];

    assign y_data = y_data_reg;
    assign sat    = sat_reg;
    assign done   = done_reg;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; clear wins over everything else.
    always_comb begin
        state_next = state_reg;
        x_ready    = 1'b0;
        a_ready    = 1'b0;
        y_valid    = 1'b0;
        busy       = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD_X;
                end
            end
            LOAD_X: begin
                x_ready = 1'b1;
                if (x_valid && col_last) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                a_ready = 1'b1;
                if (a_valid && col_last) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                y_valid = 1'b1;
                if (y_ready) begin
                    state_next = row_last ? IDLE : MAC;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    // x buffer: survives the end of a job, rewritten slot by slot on the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < COLS; i++) begin
                x_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < COLS; i++) begin
                if (x_wr[i]) begin
                    x_buf[i] <= x_data;
                end
            end
        end
    end

    // Counters, accumulator, result register and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_reg    <= '0;
            row_reg    <= '0;
            acc_reg    <= '0;
            y_data_reg <= '0;
            sat_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else if (clear) begin
            // Abort: sat and the last result are deliberately left untouched.
            col_reg  <= '0;
            row_reg  <= '0;
            acc_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        col_reg <= '0;
                        row_reg <= '0;
                        acc_reg <= '0;
                        sat_reg <= 1'b0;
                    end
                end
                LOAD_X: begin
                    if (x_fire) begin
                        col_reg <= col_last ? '0 : col_reg + 1'b1;
                    end
                end
                MAC: begin
                    if (a_fire) begin
                        acc_reg <= acc_sum;
                        if (col_last) begin
                            col_reg    <= '0;
                            y_data_reg <= y_sat;
                            if (clamp_hi || clamp_lo) begin
                                sat_reg <= 1'b1;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (y_fire) begin
                        acc_reg <= '0;
                        col_reg <= '0;
                        if (row_last) begin
                            row_reg  <= '0;
                            done_reg <= 1'b1;
                        end else begin
                            row_reg <= row_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    col_reg <= '0;
                end
            endcase
        end
    end

endmodule
